ysyx_23060203_idq: RTL and testbench
====================================

# ysyx_23060203_idq

Decode-side instruction queue with a parametrised hazard and forwarding front end, placed between IFU and the decoder/EXU. It buffers up to DEPTH fetched instructions and resolves rs1/rs2 against NFWD in-flight writeback channels. It stalls only when an operand the head instruction actually uses is not yet available. It also resolves BRANCH/JALR mispredictions at the queue head and discards the wrong-path entries queued behind it.

## Interface
- DEPTH, 2: queue entries; power of two, ≥2.
- NFWD, 2: forwarding channels; index 0 has the highest priority (youngest producer).
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  global flush from the backend.
- in_valid/in_ready  in/out  1  IFU handshake.
- in_pc, in_inst  in  32  fetched PC and instruction.
- rs1, rs2  out  5  GPR read addresses, taken from the head entry.
- src1, src2  in  32  GPR read data.
- fwd_valid  in  NFWD  channel holds an in-flight write.
- fwd_rd  in  5*NFWD  destination register per channel.
- fwd_rdy  in  NFWD  channel value is available; 0 means a load or multi-cycle result is still pending.
- fwd_val  in  32*NFWD  channel value.
- out_valid/out_ready  out/in  1  handshake to the decoder.
- out_pc, out_inst, out_src1, out_src2  out  32  head entry and its resolved operands.
- jump_flush  out  1  misprediction redirect pulse.
- jump_dnpc  out  32  redirect target; bit 0 is forced to 0.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Circular buffer with head pointer, tail pointer and occupancy counter.
- Enqueue when in_valid & in_ready. in_ready = ~full & ~flush & ~jump_flush.
- A beat presented while flush or jump_flush is high is discarded.
- Dequeue when out_valid & out_ready.
- Operand match, per operand and per channel i: fwd_valid[i] & (rs≠0) & (fwd_rd[i]==rs). The lowest matching index wins.
- Operand resolution:
  - No match: the GPR value is used.
  - Match with fwd_rdy=1: fwd_val of that channel is used.
  - Match with fwd_rdy=0: the operand is pending.
- rs1 is used by every opcode except LUI, AUIPC and JAL, and except SYS with funct3==0 or funct3[2]==1.
- rs2 is used only by BRANCH, STORE and OP (register-register).
- raw = (rs1 used & rs1 pending) | (rs2 used & rs2 pending).
- out_valid = ~empty & ~raw & ~flush.
- Branch prediction is static: backward branches (inst[31]=1) are predicted taken, JALR is always mispredicted.
- Branch compare uses the resolved operands: BEQ, BNE, BLT, BGE, BLTU, BGEU. funct3 010 and 011 are treated as not taken.
- mispredict = JALR | (BRANCH & (taken ^ inst[31])).
- jump_flush = ~empty & ~raw & ~flush & mispredict & ~head_redirected.
- jump_dnpc:
  - JALR: src1 + imm_i.
  - BRANCH with inst[31]=1: pc + 4.
  - Otherwise: pc + imm_b.
- Each entry carries a head_redirected flag, cleared on enqueue. It is set on the cycle jump_flush fires, so the pulse lasts one cycle per instruction even while the entry stalls on out_ready.
- On jump_flush, every entry behind the head is dropped: tail ← head+1, count ← 1. If the head dequeues in the same cycle, count ← 0.
- On flush: count ← 0 and tail ← head. flush has priority over jump_flush and over any handshake.

## Timing
- Reset values: count=0, head=tail=0, out_valid=0, jump_flush=0, in_ready=1, all head_redirected flags=0.
- Latency: an instruction enqueued at cycle t may appear on out_valid at t+1 at the earliest.
- Throughput: one instruction per cycle sustained when DEPTH≥2 and no stalls.
- Full: in_ready=0, even if a dequeue happens in the same cycle (no pass-through). Simultaneous enqueue and dequeue when not full leaves count unchanged.
- Empty: out_valid=0 and jump_flush=0; rs1/rs2 are don't-care.
- Pointer wrap: modulo DEPTH, no special case.
- Once asserted, out_valid and the output fields stay stable until accepted, unless flush or a change in forwarding availability deasserts them. out_src* may change while out_valid is low.
- Reset mid-operation discards all contents with no output pulse.

## Structure
- Shared package: OP_* opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, RI, RR, SYS), branch funct3 encodings, and a default DEPTH/NFWD.
- Sub-module ysyx_23060203_fwd_sel: a priority forwarding mux for one operand, with outputs value and pending. It is instantiated twice.
- Branch compare reuses the existing BRU.

## Test plan
- Fill test, DEPTH=2, out_ready=0: enqueue 3 instructions → in_ready drops after the 2nd and count=2. Then out_ready=1 → both leave in order, one per cycle.
- Forward priority: head `add x3,x1,x2`; ch0 rd=1 rdy=1 val=0x11; ch1 rd=1 rdy=1 val=0x22 → out_src1=0x11, out_valid=1.
- Pending stall on rs2: `sw x5,0(x1)`, ch1 rd=5 rdy=0 → out_valid=0. Raise rdy with val=0xAB → the next cycle out_src2=0xAB. Also check `lui x5` with a pending x5 is not stalled.
- Mispredict: head `beq x1,x2,+16` at pc 0x100 with x1==x2, two entries behind it → one-cycle jump_flush, jump_dnpc=0x110, count=1. Hold out_ready=0 for 3 cycles → no second pulse.
- JALR: src1=0x2001, imm=4 → jump_dnpc=0x2004. x0 matched on a channel with rdy=0 → no stall.
- Flush, with an enqueue and jump_flush in the same cycle → next cycle count=0, out_valid=0, and the incoming beat is dropped.

Source files
------------

// File: rtl/ysyx_23060203_idq_pkg.sv
// Shared definitions for the decode-side instruction queue: opcodes, branch
// funct3 encodings, default sizing and the branch compare unit.
package ysyx_23060203_idq_pkg;

   localparam int IDQ_DEPTH_DEF = 2;
   localparam int IDQ_NFWD_DEF  = 2;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RI     = 7'b0010011;
   localparam logic [6:0] OP_RR     = 7'b0110011;
   localparam logic [6:0] OP_SYS    = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } idq_entry_t;

   // Branch compare unit; the reserved encodings 010/011 never take.
   function automatic logic bru_taken(input logic [2:0]  f3,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
      logic taken;
      case (f3)
         F3_BEQ:  taken = (a == b);
         F3_BNE:  taken = (a != b);
         F3_BLT:  taken = ($signed(a) <  $signed(b));
         F3_BGE:  taken = ($signed(a) >= $signed(b));
         F3_BLTU: taken = (a <  b);
         F3_BGEU: taken = (a >= b);
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/ysyx_23060203_idq_fwd_sel.sv
// Priority forwarding mux for one source operand; channel 0 is the youngest
// producer and wins over every other matching channel.
module ysyx_23060203_fwd_sel #(
   parameter int NFWD = 2
) (
   input  logic [4:0]           rs_i,
   input  logic [31:0]          gpr_i,
   input  logic [NFWD-1:0]      fwd_valid_i,
   input  logic [5*NFWD-1:0]    fwd_rd_i,
   input  logic [NFWD-1:0]      fwd_rdy_i,
   input  logic [32*NFWD-1:0]   fwd_val_i,
   output logic [31:0]          val_o,
   output logic                 pending_o
);

   always_comb begin
      val_o     = gpr_i;
      pending_o = 1'b0;
      // Walk from the oldest channel up so the lowest matching index lands last.
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (fwd_valid_i[i] && (rs_i != 5'd0) && (fwd_rd_i[5*i +: 5] == rs_i)) begin
            val_o     = fwd_val_i[32*i +: 32];
            pending_o = ~fwd_rdy_i[i];
         end
      end
   end

endmodule

// File: rtl/ysyx_23060203_idq.sv
// Decode-side instruction queue: circular buffer with operand forwarding,
// RAW stall on the head entry and head-of-queue branch/JALR redirect.
module ysyx_23060203_idq
   import ysyx_23060203_idq_pkg::*;
#(
   parameter int DEPTH = IDQ_DEPTH_DEF,
   parameter int NFWD  = IDQ_NFWD_DEF
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [31:0]             in_pc_i,
   input  logic [31:0]             in_inst_i,
   output logic [4:0]              rs1_o,
   output logic [4:0]              rs2_o,
   input  logic [31:0]             src1_i,
   input  logic [31:0]             src2_i,
   input  logic [NFWD-1:0]         fwd_valid_i,
   input  logic [5*NFWD-1:0]       fwd_rd_i,
   input  logic [NFWD-1:0]         fwd_rdy_i,
   input  logic [32*NFWD-1:0]      fwd_val_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [31:0]             out_pc_o,
   output logic [31:0]             out_inst_o,
   output logic [31:0]             out_src1_o,
   output logic [31:0]             out_src2_o,
   output logic                    jump_flush_o,
   output logic [31:0]             jump_dnpc_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   idq_entry_t        mem_q [DEPTH];
   logic [DEPTH-1:0]  redir_q, redir_d;
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;

   idq_entry_t   head;
   logic         empty, full, enq, deq;
   logic [6:0]   opcode;
   logic [2:0]   funct3;
   logic         is_branch, is_jalr;
   logic         rs1_used, rs2_used, rs1_pend, rs2_pend, raw;
   logic         head_ok, taken, mispredict;
   logic [31:0]  imm_i, imm_b, target;

   assign head   = mem_q[head_q];
   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign opcode = head.inst[6:0];
   assign funct3 = head.inst[14:12];
   assign rs1_o  = head.inst[19:15];
   assign rs2_o  = head.inst[24:20];

   ysyx_23060203_fwd_sel #(.NFWD(NFWD)) u_fwd_rs1 (
      .rs_i        (rs1_o),
      .gpr_i       (src1_i),
      .fwd_valid_i (fwd_valid_i),
      .fwd_rd_i    (fwd_rd_i),
      .fwd_rdy_i   (fwd_rdy_i),
      .fwd_val_i   (fwd_val_i),
      .val_o       (out_src1_o),
      .pending_o   (rs1_pend)
   );

   ysyx_23060203_fwd_sel #(.NFWD(NFWD)) u_fwd_rs2 (
      .rs_i        (rs2_o),
      .gpr_i       (src2_i),
      .fwd_valid_i (fwd_valid_i),
      .fwd_rd_i    (fwd_rd_i),
      .fwd_rdy_i   (fwd_rdy_i),
      .fwd_val_i   (fwd_val_i),
      .val_o       (out_src2_o),
      .pending_o   (rs2_pend)
   );

   assign is_branch = (opcode == OP_BRANCH);
   assign is_jalr   = (opcode == OP_JALR);

   // CSR-immediate forms (funct3[2]) and ECALL/EBREAK/MRET (funct3 0) read no rs1.
   assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                       ((opcode == OP_SYS) && ((funct3 == 3'b000) || funct3[2])));
   assign rs2_used = is_branch || (opcode == OP_STORE) || (opcode == OP_RR);
   assign raw      = (rs1_used && rs1_pend) || (rs2_used && rs2_pend);

   assign head_ok      = !empty && !raw && !flush_i;
   assign out_valid_o  = head_ok;
   assign out_pc_o     = head.pc;
   assign out_inst_o   = head.inst;

   assign taken      = bru_taken(funct3, out_src1_o, out_src2_o);
   assign mispredict = is_jalr || (is_branch && (taken ^ head.inst[31]));
   assign jump_flush_o = head_ok && mispredict && !redir_q[head_q];

   assign imm_i = {{20{head.inst[31]}}, head.inst[31:20]};
   assign imm_b = {{20{head.inst[31]}}, head.inst[7], head.inst[30:25], head.inst[11:8], 1'b0};

   always_comb begin
      if (is_jalr)
         target = out_src1_o + imm_i;
      else if (head.inst[31])
         target = head.pc + 32'd4;
      else
         target = head.pc + imm_b;
   end
   assign jump_dnpc_o = target & 32'hFFFF_FFFE;

   assign in_ready_o = !full && !flush_i && !jump_flush_o;
   assign enq        = in_valid_i && in_ready_o;
   assign deq        = out_valid_o && out_ready_i;
   assign count_o    = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      redir_d = redir_q;
      if (flush_i) begin
         count_d = '0;
         tail_d  = head_q;
      end else begin
         if (deq)
            head_d = head_q + 1'b1;
         if (jump_flush_o) begin
            // Drop the wrong path; the head survives until it is accepted.
            tail_d           = head_q + 1'b1;
            count_d          = deq ? CW'(0) : CW'(1);
            redir_d[head_q]  = 1'b1;
         end else begin
            if (enq) begin
               tail_d          = tail_q + 1'b1;
               redir_d[tail_q] = 1'b0;
            end
            case ({enq, deq})
               2'b10:   count_d = count_q + 1'b1;
               2'b01:   count_d = count_q - 1'b1;
               default: count_d = count_q;
            endcase
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         redir_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         redir_q <= redir_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (enq)
         mem_q[tail_q] <= idq_entry_t'{pc: in_pc_i, inst: in_inst_i};
   end

endmodule

// File: tb/tb_ysyx_23060203_idq.sv
// Self-checking bench for ysyx_23060203_idq: a scoreboard follows accepted
// beats through the queue and directed checks cover forwarding and redirects.
module tb_ysyx_23060203_idq;

   localparam int DEPTH = 4;
   localparam int NFWD  = 2;

   logic              clock_i = 1'b0;
   logic              reset_i, flush_i, in_valid_i, in_ready_o;
   logic [31:0]       in_pc_i, in_inst_i;
   logic [4:0]        rs1_o, rs2_o;
   logic [31:0]       src1_i, src2_i;
   logic [NFWD-1:0]   fwd_valid_i, fwd_rdy_i;
   logic [5*NFWD-1:0] fwd_rd_i;
   logic [32*NFWD-1:0] fwd_val_i;
   logic              out_valid_o, out_ready_i, jump_flush_o;
   logic [31:0]       out_pc_o, out_inst_o, out_src1_o, out_src2_o, jump_dnpc_o;
   logic [2:0]        count_o;

   logic [31:0] gpr [32];
   assign src1_i = gpr[rs1_o];
   assign src2_i = gpr[rs2_o];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;
   exp_t sb [$];

   int n_vec = 0;
   int n_err = 0;

   always #5 clock_i = ~clock_i;

   ysyx_23060203_idq #(.DEPTH(DEPTH), .NFWD(NFWD)) dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .flush_i      (flush_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_pc_i      (in_pc_i),
      .in_inst_i    (in_inst_i),
      .rs1_o        (rs1_o),
      .rs2_o        (rs2_o),
      .src1_i       (src1_i),
      .src2_i       (src2_i),
      .fwd_valid_i  (fwd_valid_i),
      .fwd_rd_i     (fwd_rd_i),
      .fwd_rdy_i    (fwd_rdy_i),
      .fwd_val_i    (fwd_val_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_pc_o     (out_pc_o),
      .out_inst_o   (out_inst_o),
      .out_src1_o   (out_src1_o),
      .out_src2_o   (out_src2_o),
      .jump_flush_o (jump_flush_o),
      .jump_dnpc_o  (jump_dnpc_o),
      .count_o      (count_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock_i);
      #1;
   endtask

   task automatic enq1(input logic [31:0] pc, input logic [31:0] inst);
      in_valid_i = 1'b1;
      in_pc_i    = pc;
      in_inst_i  = inst;
      tick();
      in_valid_i = 1'b0;
   endtask

   // Scoreboard: sampled mid-cycle, inputs are only changed just after posedge.
   always @(negedge clock_i) begin
      if (reset_i || flush_i) begin
         sb.delete();
      end else begin
         if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("deq_pc", out_pc_o, e.pc);
               chk("deq_inst", out_inst_o, e.inst);
            end
         end
         if (jump_flush_o) begin
            if (out_valid_o && out_ready_i)
               sb.delete();
            else
               while (sb.size() > 1) void'(sb.pop_back());
         end
         if (in_valid_i && in_ready_o)
            sb.push_back('{pc: in_pc_i, inst: in_inst_i});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int r = 0; r < 32; r++) gpr[r] = (r == 0) ? 32'd0 : 32'h1000_0000 + 32'(r);
      reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_pc_i = '0; in_inst_i = '0;
      fwd_valid_i = '0; fwd_rd_i = '0; fwd_rdy_i = '0; fwd_val_i = '0; out_ready_i = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
      #1;
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_ov", 32'(out_valid_o), 32'd0);
      chk("rst_jf", 32'(jump_flush_o), 32'd0);
      chk("rst_rdy", 32'(in_ready_o), 32'd1);

      // Fill past capacity with out_ready low, then drain in order.
      for (int k = 0; k <= DEPTH; k++) begin
         in_valid_i = 1'b1;
         in_pc_i    = 32'h1000 + 32'(4 * k);
         in_inst_i  = (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13;
         #1;
         chk("fill_rdy", 32'(in_ready_o), (k < DEPTH) ? 32'd1 : 32'd0);
         if (k == 0) chk("lat_ov0", 32'(out_valid_o), 32'd0);
         tick();
      end
      in_valid_i = 1'b0;
      #1;
      chk("fill_count", 32'(count_o), 32'(DEPTH));
      chk("fill_ov", 32'(out_valid_o), 32'd1);
      out_ready_i = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         chk("drain_ov", 32'(out_valid_o), 32'd1);
         tick();
      end
      chk("drain_count", 32'(count_o), 32'd0);
      chk("drain_ov_end", 32'(out_valid_o), 32'd0);

      // Sustained enqueue+dequeue keeps occupancy at one.
      for (int k = 0; k < 3; k++) begin
         in_valid_i = 1'b1;
         in_pc_i    = 32'h1100 + 32'(4 * k);
         in_inst_i  = 32'h0000_0093 | (32'(k) << 20);
         tick();
         chk("stream_count", 32'(count_o), 32'd1);
      end
      in_valid_i = 1'b0;
      tick();
      chk("stream_empty", 32'(count_o), 32'd0);
      out_ready_i = 1'b0;

      // Forwarding priority on add x3,x1,x2.
      fwd_valid_i = 2'b11; fwd_rd_i = {5'd1, 5'd1}; fwd_rdy_i = 2'b11;
      fwd_val_i = {32'h22, 32'h11};
      enq1(32'h2000, 32'h0020_81B3);
      #1;
      chk("fwd_src1_ch0", out_src1_o, 32'h11);
      chk("fwd_ov", 32'(out_valid_o), 32'd1);
      chk("fwd_src2_gpr", out_src2_o, 32'h1000_0002);
      fwd_valid_i = 2'b10;
      #1;
      chk("fwd_src1_ch1", out_src1_o, 32'h22);
      tick();
      fwd_valid_i = 2'b11; fwd_rdy_i = 2'b10;
      #1;
      chk("fwd_ch0_pend", 32'(out_valid_o), 32'd0);
      tick();
      fwd_rdy_i = 2'b11; out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0; fwd_valid_i = '0;

      // Store stalls on pending rs2; LUI ignores its operand fields.
      fwd_valid_i = 2'b10; fwd_rd_i = {5'd5, 5'd0}; fwd_rdy_i = 2'b00;
      fwd_val_i = {32'hAB, 32'h0}; out_ready_i = 1'b1;
      enq1(32'h3000, 32'h0050_A023);
      #1;
      chk("sw_stall", 32'(out_valid_o), 32'd0);
      tick();
      chk("sw_stall2", 32'(out_valid_o), 32'd0);
      fwd_rdy_i = 2'b10;
      #1;
      chk("sw_ov", 32'(out_valid_o), 32'd1);
      chk("sw_src2", out_src2_o, 32'hAB);
      tick();
      fwd_rdy_i = 2'b00;
      enq1(32'h3004, 32'h0052_82B7);
      #1;
      chk("lui_ov", 32'(out_valid_o), 32'd1);
      tick();
      chk("lui_count", 32'(count_o), 32'd0);
      out_ready_i = 1'b0; fwd_valid_i = '0;

      // Backward branches: not-taken mispredicts to pc+4, taken is fine.
      gpr[1] = 32'h55; gpr[2] = 32'h55;
      enq1(32'h200, 32'hFE20_9CE3);
      #1;
      chk("bne_jf", 32'(jump_flush_o), 32'd1);
      chk("bne_dnpc", jump_dnpc_o, 32'h204);
      tick();
      chk("bne_jf_once", 32'(jump_flush_o), 32'd0);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      enq1(32'h210, 32'hFE20_8CE3);
      #1;
      chk("beqb_jf", 32'(jump_flush_o), 32'd0);
      chk("beqb_ov", 32'(out_valid_o), 32'd1);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;

      // Forward taken beq with two entries behind, held while rs1 is pending.
      fwd_valid_i = 2'b01; fwd_rd_i = {5'd0, 5'd1}; fwd_rdy_i = 2'b00;
      enq1(32'h100, 32'h0020_8863);
      enq1(32'h104, 32'h0010_0093);
      enq1(32'h108, 32'h0020_0113);
      #1;
      chk("mp_count3", 32'(count_o), 32'd3);
      chk("mp_jf_stall", 32'(jump_flush_o), 32'd0);
      fwd_valid_i = '0;
      #1;
      chk("mp_jf", 32'(jump_flush_o), 32'd1);
      chk("mp_dnpc", jump_dnpc_o, 32'h110);
      tick();
      chk("mp_count1", 32'(count_o), 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk("mp_no_repulse", 32'(jump_flush_o), 32'd0);
         chk("mp_hold_ov", 32'(out_valid_o), 32'd1);
         tick();
      end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      chk("mp_count0", 32'(count_o), 32'd0);

      // JALR: target from src1+imm, redirect and accept in the same cycle.
      gpr[6] = 32'h2001;
      enq1(32'h400, 32'h0043_0067);
      #1;
      chk("jalr_jf", 32'(jump_flush_o), 32'd1);
      chk("jalr_dnpc", jump_dnpc_o, 32'h2004);
      out_ready_i = 1'b1;
      tick();
      chk("jalr_count", 32'(count_o), 32'd0);
      chk("jalr_jf_end", 32'(jump_flush_o), 32'd0);
      out_ready_i = 1'b0;
      fwd_valid_i = 2'b01; fwd_rd_i = {5'd0, 5'd0}; fwd_rdy_i = 2'b00;
      enq1(32'h404, 32'h0100_00E7);
      #1;
      chk("x0_ov", 32'(out_valid_o), 32'd1);
      chk("x0_jf", 32'(jump_flush_o), 32'd1);
      chk("x0_dnpc", jump_dnpc_o, 32'h10);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0; fwd_valid_i = '0;

      // Flush beats a pending redirect and an incoming beat.
      enq1(32'h500, 32'h0020_8863);
      flush_i = 1'b1; in_valid_i = 1'b1; in_pc_i = 32'h504; in_inst_i = 32'h0030_0193;
      #1;
      chk("fl_jf", 32'(jump_flush_o), 32'd0);
      chk("fl_ov", 32'(out_valid_o), 32'd0);
      chk("fl_rdy", 32'(in_ready_o), 32'd0);
      tick();
      flush_i = 1'b0; in_valid_i = 1'b0;
      #1;
      chk("fl_count", 32'(count_o), 32'd0);
      chk("fl_ov2", 32'(out_valid_o), 32'd0);
      tick();
      chk("fl_dropped", 32'(count_o), 32'd0);

      // Reset in the middle of operation.
      enq1(32'h600, 32'h0010_0093);
      enq1(32'h604, 32'h0020_0113);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      #1;
      chk("mrst_count", 32'(count_o), 32'd0);
      chk("mrst_ov", 32'(out_valid_o), 32'd0);
      chk("mrst_jf", 32'(jump_flush_o), 32'd0);
      chk("mrst_rdy", 32'(in_ready_o), 32'd1);
      tick();

      chk("sb_leftover", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
